// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit. The control unit imports the
// same op encodings.
package mdu_pkg;

    typedef enum logic [1:0] {
        MDU_MULT  = 2'd0,
        MDU_MULTU = 2'd1,
        MDU_DIV   = 2'd2,
        MDU_DIVU  = 2'd3
    } mdu_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } mdu_state_t;

    function automatic logic op_is_div(input logic [1:0] op);
        return op[1];
    endfunction

    function automatic logic op_is_signed(input logic [1:0] op);
        return ~op[0];
    endfunction

endpackage

// File: rtl/mdu_cond_neg.sv
// Conditional two's-complement negate; used for operand magnitudes and for the
// final sign correction of products, quotients and remainders.
module mdu_cond_neg #(
    parameter int unsigned W = 32
) (
    input  logic         neg_i,
    input  logic [W-1:0] val_i,
    output logic [W-1:0] res_o
);

    assign res_o = neg_i ? -val_i : val_i;

endmodule

// File: rtl/mult_div_unit.sv
// Multicycle MULT/MULTU/DIV/DIVU unit: one bit per cycle over a shared
// 2*WIDTH accumulator, sign fix in a final cycle, results held in HI/LO.
module mult_div_unit
    import mdu_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int unsigned CW = $clog2(WIDTH + 1);

    mdu_state_t         state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    mdu_op_e            op_q, op_d;
    logic [WIDTH-1:0]   mb_q, mb_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic               neg_res_q, neg_res_d;
    logic               neg_rem_q, neg_rem_d;
    logic               zero_q, zero_d;
    logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
    logic               done_q, done_d;
    logic               dz_q, dz_d;

    logic               sgn_in;
    logic [WIDTH-1:0]   mag_a, mag_b;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quot_fix, rem_fix;
    logic [WIDTH:0]     add_sum, rem_sh, diff;

    assign sgn_in = op_is_signed(op);

    mdu_cond_neg #(.W(WIDTH)) u_neg_a (
        .neg_i(sgn_in & a[WIDTH-1]), .val_i(a), .res_o(mag_a)
    );
    mdu_cond_neg #(.W(WIDTH)) u_neg_b (
        .neg_i(sgn_in & b[WIDTH-1]), .val_i(b), .res_o(mag_b)
    );
    mdu_cond_neg #(.W(2*WIDTH)) u_neg_prod (
        .neg_i(neg_res_q), .val_i(acc_q), .res_o(prod_fix)
    );
    mdu_cond_neg #(.W(WIDTH)) u_neg_quot (
        .neg_i(neg_res_q), .val_i(acc_q[WIDTH-1:0]), .res_o(quot_fix)
    );
    mdu_cond_neg #(.W(WIDTH)) u_neg_rem (
        .neg_i(neg_rem_q), .val_i(acc_q[2*WIDTH-1:WIDTH]), .res_o(rem_fix)
    );

    // Multiply: accumulator is {partial product, multiplier}, shifted right.
    // Divide: accumulator is {remainder, quotient}, shifted left.
    assign add_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, mb_q} : '0);
    assign rem_sh  = acc_q[2*WIDTH-1:WIDTH-1];
    assign diff    = rem_sh - {1'b0, mb_q};

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        op_d      = op_q;
        mb_d      = mb_q;
        acc_d     = acc_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        zero_d    = zero_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        done_d    = 1'b0;
        dz_d      = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    op_d      = mdu_op_e'(op);
                    cnt_d     = '0;
                    neg_res_d = sgn_in & (a[WIDTH-1] ^ b[WIDTH-1]);
                    neg_rem_d = sgn_in & a[WIDTH-1];
                    zero_d    = op_is_div(op) && (b == '0);
                    if (op_is_div(op)) begin
                        mb_d  = mag_b;
                        acc_d = {{WIDTH{1'b0}}, mag_a};
                    end else begin
                        mb_d  = mag_a;
                        acc_d = {{WIDTH{1'b0}}, mag_b};
                    end
                    state_d = (op_is_div(op) && (b == '0)) ? FIX : RUN;
                end
            end
            RUN: begin
                cnt_d = cnt_q + CW'(1);
                if (op_is_div(op_q)) begin
                    acc_d = {(diff[WIDTH] ? rem_sh[WIDTH-1:0] : diff[WIDTH-1:0]),
                             acc_q[WIDTH-2:0], ~diff[WIDTH]};
                end else begin
                    acc_d = {add_sum, acc_q[WIDTH-1:1]};
                end
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                state_d = IDLE;
                done_d  = 1'b1;
                if (zero_q) begin
                    dz_d = 1'b1;
                end else if (op_is_div(op_q)) begin
                    hi_d = rem_fix;
                    lo_d = quot_fix;
                end else begin
                    {hi_d, lo_d} = prod_fix;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            op_q      <= MDU_MULT;
            mb_q      <= '0;
            acc_q     <= '0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            zero_q    <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            done_q    <= 1'b0;
            dz_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            op_q      <= op_d;
            mb_q      <= mb_d;
            acc_q     <= acc_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            zero_q    <= zero_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            done_q    <= done_d;
            dz_q      <= dz_d;
        end
    end

    assign busy     = (state_q != IDLE);
    assign done     = done_q;
    assign div_zero = dz_q;
    assign hi       = hi_q;
    assign lo       = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit at WIDTH=32 and WIDTH=8, checked against an
// integer-arithmetic reference model.
module tb_mult_div_unit;
    import mdu_pkg::*;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
        int unsigned cyc;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk  = 0;
    int n_fail = 0;

    logic        rst32, start32, busy32, done32, dz32;
    logic [1:0]  op32;
    logic [31:0] a32, b32, hi32, lo32;
    logic        rst8, start8, busy8, done8, dz8;
    logic [1:0]  op8;
    logic [7:0]  a8, b8, hi8, lo8;

    mult_div_unit #(.WIDTH(32)) u_w32 (
        .clk(clk), .reset(rst32), .start(start32), .op(op32), .a(a32), .b(b32),
        .busy(busy32), .done(done32), .div_zero(dz32), .hi(hi32), .lo(lo32)
    );
    mult_div_unit #(.WIDTH(8)) u_w8 (
        .clk(clk), .reset(rst8), .start(start8), .op(op8), .a(a8), .b(b8),
        .busy(busy8), .done(done8), .div_zero(dz8), .hi(hi8), .lo(lo8)
    );

    exp_t q32[$];
    exp_t q8[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    function automatic longint sval(input logic [31:0] v, input int unsigned w, input bit sgn);
        longint r;
        r = longint'(v) & ((longint'(1) << w) - 1);
        if (sgn && v[w-1]) r = r - (longint'(1) << w);
        return r;
    endfunction

    // Reference: plain signed/unsigned integer arithmetic on w-bit operands.
    function automatic exp_t model(input int unsigned w, input logic [1:0] op,
                                   input logic [31:0] a, input logic [31:0] b,
                                   input logic [31:0] phi, input logic [31:0] plo);
        exp_t   e;
        longint sa, sb, p, mask;
        bit     sgn;
        sgn  = (op == MDU_MULT) || (op == MDU_DIV);
        mask = (longint'(1) << w) - 1;
        sa   = sval(a, w, sgn);
        sb   = sval(b, w, sgn);
        e.dz  = 1'b0;
        e.cyc = w + 1;
        if (op == MDU_MULT || op == MDU_MULTU) begin
            p    = sa * sb;
            e.hi = 32'((p >> w) & mask);
            e.lo = 32'(p & mask);
        end else if (sb == 0) begin
            e.hi  = phi;
            e.lo  = plo;
            e.dz  = 1'b1;
            e.cyc = 1;
        end else begin
            e.hi = 32'((sa % sb) & mask);
            e.lo = 32'((sa / sb) & mask);
        end
        return e;
    endfunction

    logic [31:0] m32_hi = 0, m32_lo = 0, m8_hi = 0, m8_lo = 0;
    int unsigned last_s32 = 0, last_s8 = 0;
    bit          last_dz32 = 0, last_dz8 = 0;

    task automatic issue32(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                           input bit gap = 0, input bit have = 0,
                           input logic [31:0] ehi = 0, input logic [31:0] elo = 0);
        exp_t e;
        int unsigned s, w;
        w = 0;
        while (busy32 && w < 200) begin @(posedge clk); #1; w++; end
        chk("idle32_before_start", busy32, 0);
        start32 = 1'b1; op32 = op; a32 = a; b32 = b;
        @(posedge clk); #1;
        s = cyc;
        start32 = 1'b0; op32 = 2'($urandom); a32 = $urandom; b32 = $urandom;
        e = model(32, op, a, b, m32_hi, m32_lo);
        if (have) begin e.hi = ehi; e.lo = elo; end
        if (gap) chk("b2b_gap32", s - last_s32, last_dz32 ? 2 : 34);
        last_s32 = s; last_dz32 = e.dz;
        m32_hi = e.hi; m32_lo = e.lo;
        e.cyc += s;
        q32.push_back(e);
    endtask

    task automatic issue8(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b,
                          input bit gap = 0, input bit have = 0,
                          input logic [31:0] ehi = 0, input logic [31:0] elo = 0);
        exp_t e;
        int unsigned s, w;
        w = 0;
        while (busy8 && w < 100) begin @(posedge clk); #1; w++; end
        chk("idle8_before_start", busy8, 0);
        start8 = 1'b1; op8 = op; a8 = a; b8 = b;
        @(posedge clk); #1;
        s = cyc;
        start8 = 1'b0; op8 = 2'($urandom); a8 = 8'($urandom); b8 = 8'($urandom);
        e = model(8, op, {24'b0, a}, {24'b0, b}, m8_hi, m8_lo);
        if (have) begin e.hi = ehi; e.lo = elo; end
        if (gap) chk("b2b_gap8", s - last_s8, last_dz8 ? 2 : 10);
        last_s8 = s; last_dz8 = e.dz;
        m8_hi = e.hi; m8_lo = e.lo;
        e.cyc += s;
        q8.push_back(e);
    endtask

    exp_t        e32, e8;
    logic [31:0] h32_hi = 0, h32_lo = 0, h8_hi = 0, h8_lo = 0;

    always @(negedge clk) begin
        if (rst32) begin
            q32.delete(); h32_hi = '0; h32_lo = '0;
        end else if (done32) begin
            if (q32.size() == 0) begin
                n_chk++; n_fail++;
                $display("FAIL done32_unexpected: actual done=1 required no pulse at cycle %0d", cyc);
            end else begin
                e32 = q32.pop_front();
                chk("hi32", hi32, e32.hi);
                chk("lo32", lo32, e32.lo);
                chk("div_zero32", dz32, e32.dz);
                chk("latency32", cyc, e32.cyc);
                chk("busy32_in_done", busy32, 0);
                h32_hi = e32.hi; h32_lo = e32.lo;
            end
        end else begin
            chk("hold32_hi", hi32, h32_hi);
            chk("hold32_lo", lo32, h32_lo);
            chk("dz32_without_done", dz32, 0);
        end
    end

    always @(negedge clk) begin
        if (rst8) begin
            q8.delete(); h8_hi = '0; h8_lo = '0;
        end else if (done8) begin
            if (q8.size() == 0) begin
                n_chk++; n_fail++;
                $display("FAIL done8_unexpected: actual done=1 required no pulse at cycle %0d", cyc);
            end else begin
                e8 = q8.pop_front();
                chk("hi8", {24'b0, hi8}, e8.hi);
                chk("lo8", {24'b0, lo8}, e8.lo);
                chk("div_zero8", dz8, e8.dz);
                chk("latency8", cyc, e8.cyc);
                chk("busy8_in_done", busy8, 0);
                h8_hi = e8.hi; h8_lo = e8.lo;
            end
        end else begin
            chk("hold8_hi", {24'b0, hi8}, h8_hi);
            chk("hold8_lo", {24'b0, lo8}, h8_lo);
            chk("dz8_without_done", dz8, 0);
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: actual time limit reached required test completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst32 = 1'b1; start32 = 1'b0; op32 = '0; a32 = '0; b32 = '0;
        rst8  = 1'b1; start8  = 1'b0; op8  = '0; a8  = '0; b8  = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy32", busy32, 0); chk("rst_done32", done32, 0); chk("rst_dz32", dz32, 0);
        chk("rst_hi32", hi32, 0);     chk("rst_lo32", lo32, 0);
        chk("rst_busy8", busy8, 0);   chk("rst_done8", done8, 0);   chk("rst_dz8", dz8, 0);
        chk("rst_hi8", hi8, 0);       chk("rst_lo8", lo8, 0);
        rst32 = 1'b0; rst8 = 1'b0;

        issue32(MDU_MULT,  32'hFFFF_FFFD, 32'd7,        0, 1, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
        issue32(MDU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 1, 32'hFFFF_FFFE, 32'h0000_0001);
        issue32(MDU_DIV,   32'hFFFF_FFF9, 32'd2,        1, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        issue32(MDU_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 1, 1, 32'h0000_0000, 32'h8000_0000);
        issue32(MDU_DIVU,  32'h0000_2211, 32'h0000_0100, 1, 1, 32'h0000_0011, 32'h0000_0022);
        issue32(MDU_DIVU,  32'd100,       32'd0,        1);
        for (int i = 0; i < 24; i++) begin
            logic [1:0]  rop;
            logic [31:0] ra, rb;
            rop = 2'($urandom); ra = $urandom; rb = $urandom;
            case ($urandom_range(0, 7))
                0: rb = '0;
                1: begin ra = 32'h8000_0000; rb = '1; end
                2: rb = 32'd1;
                default: ;
            endcase
            issue32(rop, ra, rb, 1);
        end

        issue8(MDU_DIVU, 8'd200, 8'd7, 0, 1, 32'd4, 32'd28);
        // A second request while busy must be dropped.
        @(posedge clk); #1;
        start8 = 1'b1; op8 = MDU_MULTU; a8 = 8'hFF; b8 = 8'hFF;
        @(posedge clk); #1;
        start8 = 1'b0;
        issue8(MDU_MULT, 8'h81, 8'h03);

        // Abort a division mid-iteration.
        issue8(MDU_DIVU, 8'd250, 8'd3);
        repeat (3) @(posedge clk);
        #1;
        rst8 = 1'b1;
        @(posedge clk); #1;
        chk("midrst_busy8", busy8, 0);
        chk("midrst_hi8", hi8, 0);
        chk("midrst_lo8", lo8, 0);
        chk("midrst_done8", done8, 0);
        m8_hi = '0; m8_lo = '0;
        rst8 = 1'b0;
        repeat (14) @(posedge clk);
        #1;

        for (int i = 0; i < 200; i++) begin
            logic [1:0] rop;
            logic [7:0] ra, rb;
            rop = 2'($urandom); ra = 8'($urandom); rb = 8'($urandom);
            case ($urandom_range(0, 7))
                0: rb = '0;
                1: begin ra = 8'h80; rb = '1; end
                2: rb = 8'd1;
                default: ;
            endcase
            issue8(rop, ra, rb, i > 0);
        end

        begin
            int unsigned w;
            w = 0;
            while ((q32.size() != 0 || q8.size() != 0) && w < 100) begin
                @(posedge clk); w++;
            end
            if (q32.size() != 0 || q8.size() != 0) begin
                n_chk++; n_fail++;
                $display("FAIL drain: actual %0d/%0d results outstanding required 0/0",
                         q32.size(), q8.size());
            end
        end
        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
